// File: rtl/seg_scan_mux.sv
// Multiplexed scan driver for a common-anode seven-segment display with tear-free frame commits.
// Optional leading-zero suppression is enabled by defining SEG_SCAN_LEADING_ZERO_BLANK_EN.
module seg_scan_mux #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic                  load,
    input  logic                  blank,
    output logic [3:0]            nibble_out,
    output logic [DIGITS-1:0]     digit_en_n,
    output logic                  frame_done
);

    localparam int CNT_W = $clog2(PRESCALE + 1);
    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PRESCALE);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    typedef enum logic {SHOW, DEAD} state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [4*DIGITS-1:0]   display_q, display_d;
    logic [4*DIGITS-1:0]   shadow_q, shadow_d;
    logic                  pending_q, pending_d;
    logic [3:0]            nibble_q, nibble_d;
    logic [DIGITS-1:0]     digit_en_n_q, digit_en_n_d;
    logic                  frame_done_q, frame_done_d;
    logic [DIGITS-1:0]     lz_mask;

    function automatic logic [3:0] get_nibble(input logic [4*DIGITS-1:0] v,
                                              input logic [IDX_W-1:0] i);
        logic [3:0] r;
        r = 4'h0;
        for (int k = 0; k < DIGITS; k++) begin
            if (i == IDX_W'(k)) r = v[4*k +: 4];
        end
        return r;
    endfunction

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    // Bit k set when digit k and every digit above it are zero; digit 0 is never suppressed.
    function automatic logic [DIGITS-1:0] lz_blank_mask(input logic [4*DIGITS-1:0] v);
        logic [DIGITS-1:0] m;
        logic              upper_zero;
        m          = '0;
        upper_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            upper_zero = upper_zero & (v[4*k +: 4] == 4'h0);
            m[k]       = upper_zero;
        end
        return m;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= SHOW;
            idx_q        <= '0;
            cnt_q        <= '0;
            display_q    <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            nibble_q     <= 4'h0;
            digit_en_n_q <= '1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            display_q    <= display_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            nibble_q     <= nibble_d;
            digit_en_n_q <= digit_en_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Scan sequencing: cnt runs 1..PRESCALE while lit; idx steps as the dead cycle ends.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        frame_done_d = 1'b0;
        case (state_q)
            SHOW: begin
                if (cnt_q == CNT_MAX) begin
                    state_d = DEAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DEAD: begin
                state_d      = SHOW;
                cnt_d        = CNT_W'(1);
                idx_d        = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                frame_done_d = (idx_q == IDX_LAST);
            end
        endcase
    end

    // Loads park in the shadow and only reach the display at the frame wrap.
    always_comb begin
        display_d = display_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (frame_done_d) begin
            if (load) begin
                display_d = value_in;
                shadow_d  = value_in;
            end else if (pending_q) begin
                display_d = shadow_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            shadow_d  = value_in;
            pending_d = 1'b1;
        end
    end

    always_comb begin
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
        lz_mask = lz_blank_mask(display_d);
`else
        lz_mask = '0;
`endif
        nibble_d     = nibble_q;
        digit_en_n_d = '1;
        if (state_d == SHOW) begin
            nibble_d = get_nibble(display_d, idx_d);
            if (!blank) begin
                for (int k = 0; k < DIGITS; k++) begin
                    if (idx_d == IDX_W'(k) && !lz_mask[k]) digit_en_n_d[k] = 1'b0;
                end
            end
        end
    end

    assign nibble_out = nibble_q;
    assign digit_en_n = digit_en_n_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomized and directed bench for seg_scan_mux, checked against a time-based reference model.
module tb_seg_scan_mux;

    localparam int DIGITS   = 4;
    localparam int PRESCALE = 4;
    localparam int SLOT     = PRESCALE + 1;
    localparam int FRAME    = DIGITS * SLOT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value_in;
    logic        load;
    logic        blank;
    logic [3:0]  nibble_out;
    logic [3:0]  digit_en_n;
    logic        frame_done;

    always #5 clk = ~clk;

    seg_scan_mux #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value_in   (value_in),
        .load       (load),
        .blank      (blank),
        .nibble_out (nibble_out),
        .digit_en_n (digit_en_n),
        .frame_done (frame_done)
    );

    int checks = 0;
    int errors = 0;

    // Model state: t counts edges since reset released; everything else derives from t.
    int          t;
    logic [15:0] m_disp;
    logic [15:0] m_shadow;
    bit          m_pend;
    logic [3:0]  m_nib;
    logic [3:0]  m_en;
    logic        m_fd;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d act=%0h exp=%0h", tag, t, act, exp);
        end
    endtask

    task automatic model_step();
        int p;
        int slot;
        bit wrap;
        if (!rst_n) begin
            t        = 0;
            m_disp   = '0;
            m_shadow = '0;
            m_pend   = 0;
            m_nib    = 4'h0;
            m_en     = 4'hF;
            m_fd     = 1'b0;
        end else begin
            t++;
            p    = (t - 1) % FRAME;
            wrap = (p == 0) && (t > 1);
            if (wrap) begin
                if (load) m_disp = value_in;
                else if (m_pend) m_disp = m_shadow;
                m_pend = 0;
            end else if (load) begin
                m_shadow = value_in;
                m_pend   = 1;
            end
            m_fd = wrap;
            slot = p / SLOT;
            m_en = 4'hF;
            if ((p % SLOT) < PRESCALE) begin
                m_nib = 4'((m_disp >> (4 * slot)) & 16'hF);
                if (!blank) m_en = ~(4'b0001 << slot);
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
                if (slot > 0 && (m_disp >> (4 * slot)) == 16'h0) m_en = 4'hF;
`endif
            end
        end
    endtask

    task automatic cyc(input logic rst_i, input logic ld_i, input logic [15:0] v_i, input logic blk_i);
        @(negedge clk);
        rst_n    = rst_i;
        load     = ld_i;
        value_in = v_i;
        blank    = blk_i;
        @(posedge clk);
        model_step();
        #1;
        chk("digit_en_n", 32'(digit_en_n), 32'(m_en));
        chk("nibble_out", 32'(nibble_out), 32'(m_nib));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 16'($urandom), 1'b0);
    endtask

    // Idle until the next edge lands at frame position p_target.
    task automatic go_to(input int p_target);
        for (int n = 0; n < 2 * FRAME && (t % FRAME) != p_target; n++) idle();
    endtask

    initial begin
        int blank_left;
        t        = 0;
        rst_n    = 1'b0;
        load     = 1'b0;
        value_in = '0;
        blank    = 1'b0;
        m_disp   = '0;
        m_shadow = '0;
        m_pend   = 0;
        m_nib    = 4'h0;
        m_en     = 4'hF;
        m_fd     = 1'b0;

        // Reset, then load 0x1234 on the second edge; it appears from the first wrap.
        cyc(1'b0, 1'b0, 16'h0, 1'b0);
        cyc(1'b0, 1'b0, 16'h0, 1'b0);
        idle();
        cyc(1'b1, 1'b1, 16'h1234, 1'b0);
        repeat (43) idle();

        // Mid-frame load must not tear the current frame.
        go_to(6);
        cyc(1'b1, 1'b1, 16'hABCD, 1'b0);
        repeat (40) idle();

        // Last load before the wrap wins.
        go_to(3);
        cyc(1'b1, 1'b1, 16'h1111, 1'b0);
        go_to(12);
        cyc(1'b1, 1'b1, 16'h2222, 1'b0);
        repeat (25) idle();

        // Load exactly on the commit edge.
        go_to(0);
        cyc(1'b1, 1'b1, 16'h5A5A, 1'b0);
        repeat (45) idle();

        // Blank for 7 cycles starting inside the digit-2 slot.
        go_to(11);
        repeat (7) cyc(1'b1, 1'b0, 16'($urandom), 1'b1);
        repeat (30) idle();

        // Reset during digit 2 with a load pending.
        go_to(3);
        cyc(1'b1, 1'b1, 16'h7777, 1'b0);
        go_to(11);
        cyc(1'b0, 1'b0, 16'h0, 1'b0);
        repeat (45) idle();

        // Leading-zero patterns.
        cyc(1'b1, 1'b1, 16'h0050, 1'b0);
        repeat (45) idle();
        cyc(1'b1, 1'b1, 16'h0000, 1'b0);
        repeat (45) idle();

        // Random traffic.
        blank_left = 0;
        for (int i = 0; i < 800; i++) begin
            logic        r_rst;
            logic        r_ld;
            logic [15:0] r_v;
            r_rst = ($urandom_range(0, 199) != 0);
            r_ld  = ($urandom_range(0, 7) == 0);
            r_v   = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            if (blank_left == 0 && $urandom_range(0, 29) == 0) blank_left = $urandom_range(1, 9);
            cyc(r_rst, r_ld, r_v, blank_left != 0);
            if (blank_left != 0) blank_left--;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Time-multiplexed scan driver for a common-anode multi-digit seven-segment display.
- Holds a packed hex value and selects one digit per scan slot.
- Drives that digit's nibble to the downstream seven-segment decoder and enables the matching active-low anode.
- Sits directly upstream of the decoder: its nibble_out feeds the decoder input, and digit_en_n goes to the board anodes.

Parameters:
DIGITS, 4, number of display digits (2..8)
PRESCALE, 50000, clk cycles each digit is lit per slot (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous reset, active-low
value_in  in  4*DIGITS  packed hex value, digit 0 = bits [3:0]
load  in  1  one-cycle strobe, captures value_in
blank  in  1  level, forces all anodes off while high
nibble_out  out  4  hex digit to seven-segment decoder
digit_en_n  out  DIGITS  active-low anode enables, at most one low
frame_done  out  1  one-cycle pulse at each frame wrap

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, synchronous and active-low: sampled only on rising edge of clk.
- All outputs come directly from flops.
- Reset values: digit_en_n all ones, nibble_out 0, frame_done 0. Internal reset values: display_reg 0, shadow_reg 0, pending 0, idx 0, prescale count 0, state SHOW.
- State machine, two states:
  - SHOW: anode idx low (unless blanked), nibble_out = display_reg[idx]. Lasts exactly PRESCALE cycles, then moves to DEAD.
  - DEAD: all anodes high for exactly 1 cycle (anti-ghosting). nibble_out holds the previous value. idx advances, wrapping DIGITS-1 -> 0. Then returns to SHOW.
- Observed timing after first edge with rst_n=1:
  - digit 0 lit for PRESCALE cycles, 1 dead cycle, digit 1 lit, and so on.
  - Frame period = DIGITS*(PRESCALE+1) cycles.
- Load / commit (tear-free update):
  - load=1 sets shadow_reg <= value_in and pending <= 1.
  - On the DEAD cycle where idx wraps to 0: if pending, display_reg <= shadow_reg and pending <= 0.
  - frame_done = 1 on that same edge's output cycle, whether or not a commit occurred.
  - The new value is therefore never shown mid-frame.
- Simultaneous load and commit edge: display_reg <= value_in directly, pending stays 0.
- Back-to-back loads before commit: the last one wins; no queueing.
- blank: while high, digit_en_n = all ones. The scan counters, idx and frame_done continue unaffected. Release takes effect on the next edge, mid-slot if necessary.
- Reset mid-operation: the next edge forces all reset values; the scan restarts at digit 0 and any pending load is discarded.
- Prescale counter width: clog2(PRESCALE+1). Wrap is exact, with no off-by-one. PRESCALE=1 gives a 1-cycle lit slot.

Optional Feature:
- Macro: SEG_SCAN_LEADING_ZERO_BLANK_EN.
- Defined: during a SHOW slot, the anode for digit i stays high when every display_reg nibble at index >= i is 0, for i > 0. Digit 0 is always lit, so a value of 0 shows a single "0". Slot timing is unchanged.
- Undefined: all digits are lit per the scan; the logic is absent.

Test Plan:
Use DIGITS=4, PRESCALE=4 (frame = 20 cycles).
1. Release reset, load 0x1234 on cycle 2 -> digits show 0 until the first wrap. From frame 2: slots show nibble 4,3,2,1 with digit_en_n 1110, 1101, 1011, 0111, each 4 cycles followed by one 1111 cycle. frame_done pulses every 20 cycles.
2. With 0x1234 displayed, load 0xABCD during the digit-1 slot -> digits 2 and 3 still show 2,1. Next frame shows D,C,B,A; commit coincides with the frame_done pulse.
3. Load 0x1111 then 0x2222 within one frame; separately, load exactly on the commit edge -> first case shows 2222 next frame. Second case shows the strobed value immediately, and no extra commit follows.
4. Assert blank for 7 cycles mid digit-2 slot -> digit_en_n = 1111 throughout. idx continues, frame_done timing is unchanged, and the scan resumes on the correct digit.
5. Drop rst_n for 1 cycle during the digit-2 slot with a load pending -> next edge shows digit_en_n 1111 and nibble_out 0. Digit 0 is lit on the following edge, showing 0, and the pending value is lost.
6. With SEG_SCAN_LEADING_ZERO_BLANK_EN defined, display 0x0050 -> only digits 0 and 1 are lit, showing 0 and 5. Display 0x0000 -> only digit 0 is lit, showing 0. With the macro undefined, 0x0050 lights all four digits.
